// File: rtl/gray_updown_counter.sv
// -----------------------------------------------------------------------------
// gray_updown_counter
//
// Purpose:
//   Parametrised up/down Gray-code counter for FIFO pointers and clock-domain
//   crossing counters. A binary register and a Gray register are updated on
//   the same edge, so gray_out comes straight from a flop and a synchronizer
//   in another domain sees at most one bit change per count.
//
// Parameters:
//   DATA_WIDTH : counter width in bits (>= 2)
//   SATURATE   : 0 = wrap at the ends, 1 = hold at all-ones (up) / zero (down)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   count enable
//   up_dn      in   1 = increment, 0 = decrement (used only when en=1)
//   clr        in   synchronous clear to zero (highest priority)
//   load       in   synchronous load of load_gray
//   load_gray  in   Gray-encoded value to load
//   gray_out   out  registered Gray count
//   bin_out    out  registered binary count
//   gray_next  out  Gray value gray_out takes at the next edge (look-ahead)
//   tc         out  terminal count: en=1 and at the end for the current direction
//   wrap       out  registered one-cycle pulse after a wrap (SATURATE=0 only)
// -----------------------------------------------------------------------------
module gray_updown_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_gray,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic [DATA_WIDTH-1:0] gray_next,
  output logic                  tc,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  // Prefix XOR from the MSB down: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
  function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] r_bin;
  logic [DATA_WIDTH-1:0] r_gray;
  logic                  r_wrap;

  logic [DATA_WIDTH-1:0] w_bin_d;
  logic [DATA_WIDTH-1:0] w_gray_d;
  logic                  w_wrap_d;
  logic                  w_at_top;
  logic                  w_at_bot;

  assign w_at_top = &r_bin;
  assign w_at_bot = (r_bin == '0);
  assign tc       = en && (up_dn ? w_at_top : w_at_bot);

  // Next-state with priority clr > load > en > hold.
  always_comb begin
    // NOTE: every variable gets a default before the branches, so no path
    // leaves it unassigned and no latch is inferred.
    w_bin_d  = r_bin;
    w_wrap_d = 1'b0;
    if (clr) begin
      w_bin_d = '0;
    end else if (load) begin
      w_bin_d = gray2bin(load_gray);
    end else if (en) begin
      if (tc && (SATURATE != 0)) begin
        w_bin_d = r_bin;                       // pinned at the end
      end else begin
        w_bin_d  = up_dn ? (r_bin + ONE) : (r_bin - ONE);
        w_wrap_d = tc;                         // crossing the end is a wrap
      end
    end
    // The Gray register is always the encoding of the next binary value, so a
    // load reproduces load_gray exactly and a count moves a single bit.
    w_gray_d = w_bin_d ^ (w_bin_d >> 1);
  end

  assign gray_next = w_gray_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_d;
      r_gray <= w_gray_d;
      r_wrap <= w_wrap_d;
    end
  end

  assign gray_out = r_gray;
  assign bin_out  = r_bin;
  assign wrap     = r_wrap;

`ifndef SYNTHESIS
  a_gray_matches_bin: assert property (
    @(posedge clk) disable iff (!rst_n)
      gray_out == (bin_out ^ (bin_out >> 1))
  );

  a_single_bit_step: assert property (
    @(posedge clk) disable iff (!rst_n)
      (en && !clr && !load) |=> ($countones(gray_out ^ $past(gray_out)) <= 1)
  );
`endif

endmodule
